// File: rtl/fsm_bit_serialiser_if.sv
// fsm_bit_serialiser_if
//   Handshake/serial bundle between a word source (bench or controller)
//   and the bit serialiser that feeds the sequence-detector FSMs.
//
//   master (word source) drives : load, data, len, hold
//   slave  (serialiser)  drives : ready, X, valid, done
//
//   load  : request to start a word (taken only while ready=1)
//   data  : word to send, bits [len-1:0] used
//   len   : bit count, 0 or >WIDTH means WIDTH
//   hold  : freeze shifting while high
//   ready : serialiser idle, load will be accepted
//   X     : registered serial bit, MSB first
//   valid : X carries a payload (or parity) bit
//   done  : one-cycle pulse after the last bit
interface fsm_bit_serialiser_if #(
  parameter int WIDTH = 8
);
  localparam int LW = $clog2(WIDTH) + 1;

  logic             load;
  logic [WIDTH-1:0] data;
  logic [LW-1:0]    len;
  logic             hold;
  logic             ready;
  logic             X;
  logic             valid;
  logic             done;

  modport master (
    output load, data, len, hold,
    input  ready, X, valid, done
  );

  modport slave (
    input  load, data, len, hold,
    output ready, X, valid, done
  );
endinterface

// File: rtl/fsm_bit_serialiser.sv
// fsm_bit_serialiser
//   Parallel-to-serial feeder for the Mealy/Moore sequence detectors.
//   A word accepted on load (while ready) is driven MSB-first onto X, one
//   bit per clk; hold freezes the stream, done pulses for one cycle after
//   the last bit. All outputs are registered.
//
//   Parameters : WIDTH      max word length (2..32)
//                IDLE_LEVEL level on X while no word is being sent
//   Ports      : clk        system clock, posedge
//                reset      asynchronous, active-high, forces IDLE
//                bus        fsm_bit_serialiser_if.slave
//                           (load/data/len/hold in, ready/X/valid/done out)
//   Build option: FSM_SERIAL_PARITY_EN appends an even-parity bit
//                 (XOR of the sent data bits) after the last data bit.
module fsm_bit_serialiser #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  fsm_bit_serialiser_if.slave  bus
);
  localparam int            LW    = $clog2(WIDTH) + 1;
  localparam logic [LW-1:0] W_LEN = LW'(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sr;     // bits still to be put on X, MSB next
  logic [LW-1:0]    r_cnt;    // bits left including the one on X
  logic             r_x;
  logic             r_valid;
  logic             r_done;
  logic             r_ready;

  logic [LW-1:0]    w_len_eff;
  logic [LW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_aligned;
  logic             w_last;   // bit now on X is the final one of the word

  // Left-align the used bits so data[len_eff-1] sits at the MSB; the
  // shift pushes unused upper bits out and fills the bottom with zeros.
  always_comb begin
    w_len_eff = (bus.len == '0 || bus.len > W_LEN) ? W_LEN : bus.len;
    w_shamt   = W_LEN - w_len_eff;
    w_aligned = bus.data << w_shamt;
  end

`ifdef FSM_SERIAL_PARITY_EN
  logic r_par;     // even parity of the accepted word
  logic r_par_ph;  // parity bit is currently on X
  logic w_par_step;

  // The counter parks at 1 for the last data bit; the parity phase flag
  // stretches that slot by one more bit instead of letting it wrap.
  always_comb begin
    w_last     = (r_cnt == LW'(1)) &&  r_par_ph;
    w_par_step = (r_cnt == LW'(1)) && !r_par_ph;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par    <= 1'b0;
      r_par_ph <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_par_ph <= 1'b0;
          if (bus.load) r_par <= ^w_aligned;
        end
        S_SHIFT: if (!bus.hold && w_par_step) r_par_ph <= 1'b1;
        default: r_par_ph <= 1'b0;
      endcase
    end
  end
`else
  always_comb w_last = (r_cnt == LW'(1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_x     <= IDLE_LEVEL;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_state <= S_SHIFT;
            r_x     <= w_aligned[WIDTH-1];
            r_sr    <= w_aligned << 1;
            r_cnt   <= w_len_eff;
            r_valid <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (!bus.hold) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_x     <= IDLE_LEVEL;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
`ifdef FSM_SERIAL_PARITY_EN
            end else if (w_par_step) begin
              r_x     <= r_par;
`endif
            end else begin
              r_x     <= r_sr[WIDTH-1];
              r_sr    <= r_sr << 1;
              r_cnt   <= r_cnt - LW'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_x     <= IDLE_LEVEL;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.X     = r_x;
  assign bus.valid = r_valid;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_fsm_bit_serialiser.sv
module tb_fsm_bit_serialiser;
  localparam int   WIDTH      = 8;
  localparam int   LW         = $clog2(WIDTH) + 1;
  localparam logic IDLE_LEVEL = 1'b0;
`ifdef FSM_SERIAL_PARITY_EN
  localparam int   PAR = 1;
`else
  localparam int   PAR = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fsm_bit_serialiser_if #(.WIDTH(WIDTH)) bus ();

  fsm_bit_serialiser #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---- reference model: the word as a list of bits on the line ----
  function automatic int len_eff(input int l);
    return (l == 0 || l > WIDTH) ? WIDTH : l;
  endfunction

  function automatic int n_bits(input int l);
    return len_eff(l) + PAR;
  endfunction

  // Bit i on the line (0 = first sent); index le is the parity bit.
  function automatic logic exp_bit(input logic [WIDTH-1:0] d, input int l, input int i);
    int   le;
    logic p;
    le = len_eff(l);
    p  = 1'b0;
    if (i < le) return d[le-1-i];
    for (int j = 0; j < le; j++) p ^= d[j];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word and follow it against the model through DONE and back
  // to IDLE. hmask bit c is the hold level driven for the edge after
  // cycle c of the word; mid_load keeps load high while busy.
  task automatic send_word(input logic [WIDTH-1:0] d, input int l,
                           input logic [31:0] hmask, input logic mid_load,
                           input string tag);
    int         nb, pos, cyc, guard;
    logic [3:0] exp, obs;
    nb    = n_bits(l);
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_wait: ready=%b want 1", tag, bus.ready);
      return;
    end
    bus.load = 1'b1;
    bus.data = d;
    bus.len  = LW'(l);
    bus.hold = 1'($urandom_range(0, 1));
    tick();
    bus.load = 1'b0;
    bus.data = WIDTH'($urandom);
    bus.len  = LW'($urandom);
    pos = 0;
    cyc = 0;
    while (pos < nb && cyc < 200) begin
      exp = {1'b0, 1'b1, 1'b0, exp_bit(d, l, pos)};
      obs = {bus.ready, bus.valid, bus.done, bus.X};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s bit%0d cyc%0d: {ready,valid,done,X}=%b want %b", tag, pos, cyc, obs, exp);
      end
      bus.hold = (cyc < 32) ? hmask[cyc] : 1'b0;
      bus.load = mid_load;
      tick();
      if (!bus.hold) pos++;
      cyc++;
    end
    n_checks++;
    if (pos < nb) begin
      n_fail++;
      $display("FAIL %s stream_timeout: pos=%0d want %0d", tag, pos, nb);
    end
    exp = {1'b0, 1'b0, 1'b1, IDLE_LEVEL};
    obs = {bus.ready, bus.valid, bus.done, bus.X};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s done_cycle: {ready,valid,done,X}=%b want %b", tag, obs, exp);
    end
    bus.hold = 1'($urandom_range(0, 1));
    bus.load = mid_load;  // sampled only once ready is back
    tick();
    bus.load = 1'b0;
    bus.hold = 1'b0;
    exp = {1'b1, 1'b0, 1'b0, IDLE_LEVEL};
    obs = {bus.ready, bus.valid, bus.done, bus.X};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s back_idle: {ready,valid,done,X}=%b want %b", tag, obs, exp);
    end
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    // power-on reset
    #1;
    obs = {bus.ready, bus.valid, bus.done, bus.X};
    n_checks++;
    if (obs !== {3'b100, IDLE_LEVEL}) begin
      n_fail++;
      $display("FAIL reset_por: {ready,valid,done,X}=%b want %b", obs, {3'b100, IDLE_LEVEL});
    end
    @(negedge clk) reset = 1'b0;
    // busy with all-ones so X is 1 when reset hits between edges
    bus.load = 1'b1; bus.data = 8'hFF; bus.len = LW'(8);
    tick();
    bus.load = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    obs = {bus.ready, bus.valid, bus.done, bus.X};
    n_checks++;
    if (obs !== {3'b100, IDLE_LEVEL}) begin
      n_fail++;
      $display("FAIL reset_async: {ready,valid,done,X}=%b want %b", obs, {3'b100, IDLE_LEVEL});
    end
    tick();
    tick();
    @(negedge clk) reset = 1'b0;
    tick();
    obs = {bus.ready, bus.valid, bus.done, bus.X};
    n_checks++;
    if (obs !== {3'b100, IDLE_LEVEL}) begin
      n_fail++;
      $display("FAIL reset_release: {ready,valid,done,X}=%b want %b", obs, {3'b100, IDLE_LEVEL});
    end
  endtask

  task automatic test_full_word();
    send_word(8'b1011_0010, 8, 32'h0, 1'b0, "full_word");
  endtask

  task automatic test_short_word();
    send_word(8'hF5, 3, 32'h0, 1'b0, "short_len3");
    send_word(8'h5C, 0, 32'h0, 1'b0, "len0_as_width");
    send_word(8'h93, 13, 32'h0, 1'b0, "len_over_width");
    send_word(8'h01, 1, 32'h0, 1'b0, "len1");
    send_word(8'h00, 1, 32'h0, 1'b0, "len1_zero");
  endtask

  task automatic test_hold_load();
    // hold for 3 edges while the second bit is on X, load high throughout
    send_word(8'hA0, 4, 32'b1110, 1'b1, "hold_load");
    send_word(8'hC3, 8, 32'h0000_00F0 | 32'h1, 1'b1, "hold_first_last");
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs;
    bus.load = 1'b1; bus.data = 8'hA5; bus.len = LW'(8);
    tick();
    bus.load = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (bus.X !== exp_bit(8'hA5, 8, 3) || bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_4th_bit: X=%b valid=%b want %b 1", bus.X, bus.valid, exp_bit(8'hA5, 8, 3));
    end
    #2 reset = 1'b1;
    #1;
    obs = {bus.ready, bus.valid, bus.done, bus.X};
    n_checks++;
    if (obs !== {3'b100, IDLE_LEVEL}) begin
      n_fail++;
      $display("FAIL rmid_async: {ready,valid,done,X}=%b want %b", obs, {3'b100, IDLE_LEVEL});
    end
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      obs = {bus.ready, bus.valid, bus.done, bus.X};
      n_checks++;
      if (obs !== {3'b100, IDLE_LEVEL}) begin
        n_fail++;
        $display("FAIL rmid_no_done c%0d: {ready,valid,done,X}=%b want %b", c, obs, {3'b100, IDLE_LEVEL});
      end
    end
    send_word(8'h6D, 8, 32'h0, 1'b0, "rmid_after");
  endtask

  task automatic test_parity();
    send_word(8'h07, 8, 32'h0, 1'b0, "parity_07");
    send_word(8'h03, 8, 32'h0, 1'b0, "parity_03");
    send_word(8'hB6, 5, 32'h0000_0100 | 32'h0000_0080, 1'b0, "parity_hold");
  endtask

  task automatic test_back_to_back();
    send_word(8'h3C, 6, 32'h0, 1'b1, "b2b_0");
    send_word(8'hE1, 2, 32'h0, 1'b1, "b2b_1");
    send_word(8'h7E, 8, 32'h0, 1'b0, "b2b_2");
  endtask

  task automatic test_random();
    for (int w = 0; w < 40; w++) begin
      send_word(WIDTH'($urandom), int'($urandom_range(0, 15)),
                $urandom & $urandom & $urandom, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.load = 1'b0;
    bus.data = '0;
    bus.len  = '0;
    bus.hold = 1'b0;
    test_reset();
    test_full_word();
    test_short_word();
    test_hold_load();
    test_reset_mid();
    test_parity();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
